serial_add_ctrl: RTL and testbench

- Bit-serial adder controller: time-multiplexes a single FullAdder bit cell over WIDTH-bit operands, one bit per clock, LSB first.
- Accepts operands on a valid/ready input handshake and returns sum and carry on a valid/ready output handshake.
- Sits between operand-producing logic and result consumers; trades latency for one-cell area.

---
 rtl/serial_add_pkg.sv | 16 +
 rtl/serial_add_ctrl_if.sv | 40 ++++
 rtl/serial_add_ctrl_fa.sv | 16 +
 rtl/serial_add_ctrl.sv | 126 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default width.
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } ctrlState_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// Optional signed-overflow flag ovf is present when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf;
`endif

   // Producer/consumer side: presents operands and accepts results
   modport master (
      output in_valid, a, b, c_in, out_ready,
`ifdef SERIAL_ADD_OVF_EN
      input  ovf,
`endif
      input  in_ready, out_valid, sum, c_out
   );

   // Controller side
   modport slave (
      input  in_valid, a, b, c_in, out_ready,
`ifdef SERIAL_ADD_OVF_EN
      output ovf,
`endif
      output in_ready, out_valid, sum, c_out
   );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder cell; the only arithmetic slice the serial controller uses.
module FullAdder (
   input  logic a,
   input  logic b,
   input  logic carryIn,
   output logic sum,
   output logic carryOut
);

   logic halfSum;

   assign halfSum  = a ^ b;
   assign sum      = halfSum ^ carryIn;
   assign carryOut = (a & b) | (carryIn & halfSum);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one FullAdder cell processes WIDTH-bit operands LSB first.
// Define SERIAL_ADD_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   serial_add_ctrl_if.slave  bus,
   output logic              busy
);

   ctrlState_e       state;
   ctrlState_e       nextState;

   logic [WIDTH-1:0] aSh;
   logic [WIDTH-1:0] bSh;
   logic [WIDTH-1:0] sumSh;
   logic             carry;
   logic [CNT_W-1:0] cnt;

   logic             accept;
   logic             lastBit;
   logic             inReady;
   logic             outValid;
   logic             faSum;
   logic             faCarry;

   FullAdder bitCell (
      .a        (aSh[0]),
      .b        (bSh[0]),
      .carryIn  (carry),
      .sum      (faSum),
      .carryOut (faCarry)
   );

   assign lastBit = (cnt == CNT_W'(WIDTH - 1));

   // Next-state and handshake decode; in_ready is suppressed while reset is held
   always_comb begin
      nextState = state;
      inReady   = 1'b0;
      outValid  = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            inReady = !rst;
            accept  = bus.in_valid && inReady;
            if (accept) begin
               nextState = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (lastBit) begin
               nextState = S_DONE;
            end
         end
         S_DONE: begin
            busy     = 1'b1;
            outValid = 1'b1;
            if (bus.out_ready) begin
               nextState = S_IDLE;
            end
         end
         default: begin
            nextState = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Operand shifters and result accumulator; sum bits enter at the MSB and walk down
   always_ff @(posedge clk) begin
      if (rst) begin
         aSh   <= '0;
         bSh   <= '0;
         sumSh <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         aSh   <= bus.a;
         bSh   <= bus.b;
         sumSh <= '0;
         carry <= bus.c_in;
         cnt   <= '0;
      end else if (state == S_RUN) begin
         aSh   <= {1'b0, aSh[WIDTH-1:1]};
         bSh   <= {1'b0, bSh[WIDTH-1:1]};
         sumSh <= {faSum, sumSh[WIDTH-1:1]};
         carry <= faCarry;
         cnt   <= cnt + CNT_W'(1);
      end
   end

`ifdef SERIAL_ADD_OVF_EN
   logic ovfR;

   // Signed overflow is the carry into the MSB differing from the carry out of it
   always_ff @(posedge clk) begin
      if (rst) begin
         ovfR <= 1'b0;
      end else if ((state == S_RUN) && lastBit) begin
         ovfR <= carry ^ faCarry;
      end
   end

   assign bus.ovf = ovfR;
`endif

   assign bus.in_ready  = inReady;
   assign bus.out_valid = outValid;
   assign bus.sum       = sumSh;
   assign bus.c_out     = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8); ovf is checked when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;
   import serial_add_pkg::*;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   int total = 0;
   int bad   = 0;

   serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation from IDLE and wait for out_valid; leaves the result in DONE
   task automatic applyStimulus(input string tag, input logic [7:0] opA, input logic [7:0] opB,
                                input logic cin, input logic [7:0] expSum, input logic expCout,
                                input logic expOvf);
      int n;
      checkOutput({tag, "/inReady"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.a        = opA;
      bus.b        = opB;
      bus.c_in     = cin;
      tick();
      bus.in_valid = 1'b0;
      bus.a        = ~opA;
      bus.b        = ~opB;
      bus.c_in     = ~cin;
      checkOutput({tag, "/busy"}, 64'(busy), 64'd1);
      n = 0;
      while (!bus.out_valid && n < 40) begin
         tick();
         n++;
      end
      checkOutput({tag, "/latency"}, 64'(n), 64'd8);
      checkOutput({tag, "/sum"}, 64'(bus.sum), 64'(expSum));
      checkOutput({tag, "/cOut"}, 64'(bus.c_out), 64'(expCout));
`ifdef SERIAL_ADD_OVF_EN
      checkOutput({tag, "/ovf"}, 64'(bus.ovf), 64'(expOvf));
`endif
   endtask

   task automatic releaseResult(input string tag);
      bus.out_ready = 1'b1;
      tick();
      checkOutput({tag, "/drainValid"}, 64'(bus.out_valid), 64'd0);
      checkOutput({tag, "/drainReady"}, 64'(bus.in_ready), 64'd1);
      checkOutput({tag, "/drainBusy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [16:0] sbQ[$];
      logic [16:0] item;
      logic [8:0]  expTotal;
      int          accepts;
      int          results;
      int          lastAcc;

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.c_in      = 1'b0;
      bus.out_ready = 1'b1;
      rst           = 1'b1;
      tick();
      tick();
      checkOutput("rstInReady", 64'(bus.in_ready), 64'd0);
      rst = 1'b0;
      #1;
      checkOutput("postRstInReady", 64'(bus.in_ready), 64'd1);
      checkOutput("postRstOutValid", 64'(bus.out_valid), 64'd0);
      checkOutput("postRstSum", 64'(bus.sum), 64'd0);
      checkOutput("postRstCOut", 64'(bus.c_out), 64'd0);
      checkOutput("postRstBusy", 64'(busy), 64'd0);
`ifdef SERIAL_ADD_OVF_EN
      checkOutput("postRstOvf", 64'(bus.ovf), 64'd0);
`endif

      applyStimulus("basic", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1);
      releaseResult("basic");
      applyStimulus("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      releaseResult("wrap");
      applyStimulus("carryIn", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
      releaseResult("carryIn");

      $display("[TB] backpressure with in_valid held during DONE");
      bus.out_ready = 1'b0;
      applyStimulus("bp", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      bus.a        = 8'h11;
      bus.b        = 8'h22;
      bus.c_in     = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bpSum", 64'(bus.sum), 64'h46);
         checkOutput("bpCOut", 64'(bus.c_out), 64'd0);
         checkOutput("bpInReady", 64'(bus.in_ready), 64'd0);
         checkOutput("bpOutValid", 64'(bus.out_valid), 64'd1);
      end
      bus.in_valid = 1'b0;
      releaseResult("bp");

      $display("[TB] reset in the middle of RUN");
      bus.in_valid = 1'b1;
      bus.a        = 8'hAB;
      bus.b        = 8'hCD;
      bus.c_in     = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checkOutput("midRstOutValid", 64'(bus.out_valid), 64'd0);
      checkOutput("midRstInReady", 64'(bus.in_ready), 64'd1);
      checkOutput("midRstBusy", 64'(busy), 64'd0);
      applyStimulus("postAbort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
      releaseResult("postAbort");

      applyStimulus("ovfPos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      releaseResult("ovfPos");
      applyStimulus("ovfNeg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      releaseResult("ovfNeg");
      applyStimulus("ovfNone", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
      releaseResult("ovfNone");

      $display("[TB] streaming with in_valid and out_ready tied high");
      accepts       = 0;
      results       = 0;
      lastAcc       = -1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.a         = 8'($urandom);
      bus.b         = 8'($urandom);
      bus.c_in      = 1'($urandom);
      for (int cyc = 0; cyc < 50; cyc++) begin
         if (bus.out_valid) begin
            if (sbQ.size() == 0) begin
               checkOutput("tpUnexpected", 64'd1, 64'd0);
            end else begin
               item     = sbQ.pop_front();
               expTotal = {1'b0, item[16:9]} + {1'b0, item[8:1]} + 9'(item[0]);
               checkOutput("tpResult", 64'({bus.c_out, bus.sum}), 64'(expTotal));
               results++;
            end
         end
         if (bus.in_ready) begin
            if (lastAcc >= 0) begin
               checkOutput("tpPeriod", 64'(cyc - lastAcc), 64'd10);
            end
            lastAcc = cyc;
            accepts++;
            sbQ.push_back({bus.a, bus.b, bus.c_in});
         end
         tick();
         bus.a    = 8'($urandom);
         bus.b    = 8'($urandom);
         bus.c_in = 1'($urandom);
      end
      bus.in_valid = 1'b0;
      checkOutput("tpAccepts", 64'(accepts), 64'd5);
      checkOutput("tpResults", 64'(results), 64'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
